// File: rtl/threshold_scan_controller.sv
// threshold_scan_controller: per-timestep sweep applying the threshold/reset rule to every neuron
//
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   start_i                 begin a scan (only honoured while idle)
//   num_neurons_i           number of neurons to scan, latched on an accepted start
//   vth_i, vreset_i         threshold (full fixed-point) and reset potential (integer part)
//   mem_read_en_o/addr_o    read request to the neuron-state RAM
//   mem_read_data_i         Vmem, valid one cycle after the read request
//   mem_write_en_o/addr_o/data_o  write-back of the updated Vmem
//   spike_valid_o, spike_id_o, spike_ready_i  spike FIFO head handshake
//   busy_o, done_o          scan in progress / one-cycle completion pulse
//   spike_count_o           spikes produced in the current or last scan
module threshold_scan_controller #(
    parameter int INTEGER_WIDTH     = 16,
    parameter int DATA_WIDTH_FRAC   = 32,
    parameter int DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int NEURON_ADDR_WIDTH = 10,
    parameter int SPIKE_FIFO_DEPTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [NEURON_ADDR_WIDTH:0]    num_neurons_i,
    input  logic signed [DATA_WIDTH-1:0]  vth_i,
    input  logic signed [INTEGER_WIDTH-1:0] vreset_i,
    output logic                          mem_read_en_o,
    output logic [NEURON_ADDR_WIDTH-1:0]  mem_read_addr_o,
    input  logic signed [DATA_WIDTH-1:0]  mem_read_data_i,
    output logic                          mem_write_en_o,
    output logic [NEURON_ADDR_WIDTH-1:0]  mem_write_addr_o,
    output logic signed [DATA_WIDTH-1:0]  mem_write_data_o,
    output logic                          spike_valid_o,
    output logic [NEURON_ADDR_WIDTH-1:0]  spike_id_o,
    input  logic                          spike_ready_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [NEURON_ADDR_WIDTH:0]    spike_count_o
);
    localparam int PW = $clog2(SPIKE_FIFO_DEPTH);
    localparam int CW = NEURON_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] num_q, num_d, idx_q, idx_d, spike_count_q;
    logic rd_valid_q, we_q, rd_en, room, clr_count, spike, push, pop;
    logic [NEURON_ADDR_WIDTH-1:0] rd_addr_q, waddr_q;
    logic signed [DATA_WIDTH-1:0] wdata_q, reset_val, new_vmem;
    logic [NEURON_ADDR_WIDTH-1:0] fifo_q [SPIKE_FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0] fifo_cnt_q;

    // Room for one more read: occupancy plus the read in flight must stay below depth.
    // Occupancy never exceeds depth, so "full" or "one short with a read in flight" is the stall.
    assign room      = !fifo_cnt_q[PW] && !(rd_valid_q && (&fifo_cnt_q[PW-1:0]));
    assign spike     = mem_read_data_i >= vth_i;
    assign reset_val = {vreset_i, {DATA_WIDTH_FRAC{1'b0}}};
    assign new_vmem  = spike ? reset_val : mem_read_data_i;
    assign push      = rd_valid_q && spike;
    assign pop       = spike_valid_o && spike_ready_i;

    assign mem_read_en_o    = rd_en;
    assign mem_read_addr_o  = rd_en ? idx_q[NEURON_ADDR_WIDTH-1:0] : '0;
    assign mem_write_en_o   = we_q;
    assign mem_write_addr_o = waddr_q;
    assign mem_write_data_o = wdata_q;
    assign spike_valid_o    = fifo_cnt_q != '0;
    assign spike_id_o       = spike_valid_o ? fifo_q[rptr_q] : '0;
    assign busy_o           = state_q != IDLE;
    assign done_o           = state_q == DONE;
    assign spike_count_o    = spike_count_q;

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        idx_d     = idx_q;
        rd_en     = 1'b0;
        clr_count = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                num_d     = num_neurons_i;
                idx_d     = '0;
                clr_count = 1'b1;
                state_d   = num_neurons_i == '0 ? DONE : SCAN;
            end
            SCAN: begin
                rd_en = room;
                if (room) begin
                    idx_d = idx_q + CW'(1);
                    if (idx_q == num_q - CW'(1)) state_d = DRAIN;
                end
            end
            // A write registered this cycle completes at the edge, so only the read
            // in flight (which still owes a write and maybe a push) and the FIFO gate exit.
            DRAIN: if (!rd_valid_q && fifo_cnt_q == '0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            num_q         <= '0;
            idx_q         <= '0;
            rd_valid_q    <= 1'b0;
            rd_addr_q     <= '0;
            we_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            fifo_cnt_q    <= '0;
            spike_count_q <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            rd_valid_q <= rd_en;
            rd_addr_q  <= mem_read_addr_o;
            we_q       <= rd_valid_q;
            if (rd_valid_q) begin
                waddr_q <= rd_addr_q;
                wdata_q <= new_vmem;
            end
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop) rptr_q <= rptr_q + PW'(1);
            if (push != pop) fifo_cnt_q <= push ? fifo_cnt_q + (PW+1)'(1) : fifo_cnt_q - (PW+1)'(1);
            if (clr_count) spike_count_q <= '0;
            else if (push) spike_count_q <= spike_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= rd_addr_q;
    end
endmodule
